// File: rtl/npu_config_regfile.sv
// Shadow/active configuration register file for the NPU: per-PE, memory and network
// config words behind a write handshake, with atomic shadow-to-active commit and readback.
module npu_config_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PE     = 16,
    parameter int ADDR_WIDTH = 6,
    parameter bit SHADOW_EN  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         wr_err,
    input  logic                         commit,
    output logic                         commit_done,
    input  logic                         rd_req,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    input  logic                         rd_active,
    output logic                         rd_valid,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_err,
    output logic [NUM_PE*DATA_WIDTH-1:0] pe_config,
    output logic [DATA_WIDTH-1:0]        memory_config,
    output logic [DATA_WIDTH-1:0]        network_config
);

    localparam int NUM_WORDS = NUM_PE + 2;
    localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = ADDR_WIDTH'(NUM_PE + 2);

    typedef enum logic {
        IDLE,
        COMMIT
    } state_t;

    state_t state_reg;

    logic [DATA_WIDTH-1:0] shadow_reg [NUM_WORDS];
    logic [DATA_WIDTH-1:0] active_reg [NUM_WORDS];

    logic wr_fire;
    logic ctrl_commit;
    logic commit_go;
    logic wr_oor;

    assign wr_ready    = (state_reg == IDLE);
    assign wr_fire     = wr_valid && (state_reg == IDLE);
    assign wr_oor      = wr_addr > CTRL_ADDR;
    assign ctrl_commit = wr_fire && (wr_addr == CTRL_ADDR) && wr_data[0];
    assign commit_go   = (state_reg == IDLE) && (commit || ctrl_commit);

    // One shadow/active pair per addressable word; the address decode is per entry.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word
            localparam logic [ADDR_WIDTH-1:0] WORD_ADDR = ADDR_WIDTH'(gi);
            logic word_wr;

            assign word_wr = wr_fire && (wr_addr == WORD_ADDR);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_reg[gi] <= '0;
                end else if (word_wr) begin
                    shadow_reg[gi] <= wr_data;
                end
            end

            if (SHADOW_EN) begin : g_shadow
                // Whole bank moves on the single COMMIT edge, so consumers never see a mix.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        active_reg[gi] <= '0;
                    end else if (state_reg == COMMIT) begin
                        active_reg[gi] <= shadow_reg[gi];
                    end
                end
            end else begin : g_through
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        active_reg[gi] <= '0;
                    end else if (word_wr) begin
                        active_reg[gi] <= wr_data;
                    end
                end
            end
        end

        for (gi = 0; gi < NUM_PE; gi++) begin : g_pe_out
            assign pe_config[gi*DATA_WIDTH +: DATA_WIDTH] = active_reg[gi];
        end
    endgenerate

    assign memory_config  = active_reg[NUM_PE];
    assign network_config = active_reg[NUM_PE+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            wr_err      <= 1'b0;
            commit_done <= 1'b0;
        end else begin
            wr_err      <= wr_fire && wr_oor;
            commit_done <= (state_reg == COMMIT);
            case (state_reg)
                IDLE:    if (commit_go) state_reg <= COMMIT;
                COMMIT:  state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Read mux; the control register and out-of-range addresses both read as zero.
    logic [DATA_WIDTH-1:0] rd_data_next;
    logic                  rd_err_next;

    always_comb begin
        rd_data_next = '0;
        rd_err_next  = rd_addr > CTRL_ADDR;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (rd_addr == ADDR_WIDTH'(i)) begin
                rd_data_next = rd_active ? active_reg[i] : shadow_reg[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            rd_data  <= rd_req ? rd_data_next : '0;
            rd_err   <= rd_req && rd_err_next;
        end
    end

endmodule

// File: tb/tb_npu_config_regfile.sv
// Bench for npu_config_regfile: shadow-mode and write-through instances driven together,
// checked every cycle against an array-based reference model.
module tb_npu_config_regfile;

    localparam int DW   = 32;
    localparam int NPE  = 16;
    localparam int AW   = 6;
    localparam int NW   = NPE + 2;
    localparam int CTRL = NPE + 2;
    localparam int VW   = NPE * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          commit = 1'b0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_active = 1'b0;

    logic          s_wr_ready, s_wr_err, s_commit_done, s_rd_valid, s_rd_err;
    logic [DW-1:0] s_rd_data, s_mem, s_net;
    logic [VW-1:0] s_pe;
    logic          w_wr_ready, w_wr_err, w_commit_done, w_rd_valid, w_rd_err;
    logic [DW-1:0] w_rd_data, w_mem, w_net;
    logic [VW-1:0] w_pe;

    always #5 clk = ~clk;

    npu_config_regfile #(.DATA_WIDTH(DW), .NUM_PE(NPE), .ADDR_WIDTH(AW), .SHADOW_EN(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(s_wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(s_wr_err), .commit(commit), .commit_done(s_commit_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_active(rd_active),
        .rd_valid(s_rd_valid), .rd_data(s_rd_data), .rd_err(s_rd_err),
        .pe_config(s_pe), .memory_config(s_mem), .network_config(s_net)
    );

    npu_config_regfile #(.DATA_WIDTH(DW), .NUM_PE(NPE), .ADDR_WIDTH(AW), .SHADOW_EN(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(w_wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(w_wr_err), .commit(commit), .commit_done(w_commit_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_active(rd_active),
        .rd_valid(w_rd_valid), .rd_data(w_rd_data), .rd_err(w_rd_err),
        .pe_config(w_pe), .memory_config(w_mem), .network_config(w_net)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: shadow bank, active bank, write-through bank, busy flag.
    logic [DW-1:0] m_sh  [NW];
    logic [DW-1:0] m_act [NW];
    logic [DW-1:0] m_wt  [NW];
    bit            m_busy;
    bit            e_wr_err, e_cdone, e_rv, e_re;
    logic [DW-1:0] e_rd_s, e_rd_w;

    task automatic model_reset();
        for (int i = 0; i < NW; i++) begin
            m_sh[i] = '0; m_act[i] = '0; m_wt[i] = '0;
        end
        m_busy = 0; e_wr_err = 0; e_cdone = 0; e_rv = 0; e_re = 0;
        e_rd_s = '0; e_rd_w = '0;
    endtask

    task automatic model_step();
        int a;
        int r;
        bit go;
        a = int'(wr_addr);
        r = int'(rd_addr);
        e_rv = rd_req; e_re = 0; e_rd_s = '0; e_rd_w = '0;
        if (rd_req) begin
            if (r < NW) begin
                e_rd_s = rd_active ? m_act[r] : m_sh[r];
                e_rd_w = m_wt[r];
            end else if (r > CTRL) begin
                e_re = 1;
            end
        end
        e_wr_err = 0; e_cdone = 0;
        if (!m_busy) begin
            go = commit;
            if (wr_valid) begin
                if (a < NW) begin
                    m_sh[a] = wr_data;
                    m_wt[a] = wr_data;
                end else if (a == CTRL) begin
                    if (wr_data[0]) go = 1;
                end else begin
                    e_wr_err = 1;
                end
            end
            m_busy = go;
        end else begin
            m_act  = m_sh;
            e_cdone = 1;
            m_busy = 0;
        end
    endtask

    task automatic check_all();
        logic [VW-1:0] pe_s;
        logic [VW-1:0] pe_w;
        for (int i = 0; i < NPE; i++) begin
            pe_s[i*DW +: DW] = m_act[i];
            pe_w[i*DW +: DW] = m_wt[i];
        end
        check("s_wr_ready", s_wr_ready, !m_busy);
        check("s_wr_err", s_wr_err, e_wr_err);
        check("s_commit_done", s_commit_done, e_cdone);
        check("s_rd_valid", s_rd_valid, e_rv);
        check("s_rd_data", s_rd_data, e_rd_s);
        check("s_rd_err", s_rd_err, e_re);
        check("s_pe_config", s_pe, pe_s);
        check("s_memory_config", s_mem, m_act[NPE]);
        check("s_network_config", s_net, m_act[NPE+1]);
        check("w_wr_ready", w_wr_ready, !m_busy);
        check("w_wr_err", w_wr_err, e_wr_err);
        check("w_commit_done", w_commit_done, e_cdone);
        check("w_rd_valid", w_rd_valid, e_rv);
        check("w_rd_data", w_rd_data, e_rd_w);
        check("w_rd_err", w_rd_err, e_re);
        check("w_pe_config", w_pe, pe_w);
        check("w_memory_config", w_mem, m_wt[NPE]);
        check("w_network_config", w_net, m_wt[NPE+1]);
    endtask

    task automatic cyc(input bit wv, input int wa, input logic [DW-1:0] wd, input bit cm,
                       input bit rq, input int ra, input bit ract);
        wr_valid = wv; wr_addr = AW'(wa); wr_data = wd; commit = cm;
        rd_req = rq; rd_addr = AW'(ra); rd_active = ract;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        $display("cyc wv=%0d wa=%0d wd=%h cm=%0d rq=%0d ra=%0d ract=%0d", wv, wa, wd, cm, rq, ra, ract);
    endtask

    task automatic do_reset();
        wr_valid = 0; commit = 0; rd_req = 0;
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        $display("reset asserted");
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        int sel;
        int wa;
        do_reset();

        // shadow isolation
        cyc(1, 3, 32'hA5A5_0003, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 3, 0);
        check("shadow_rd", s_rd_data, 32'hA5A5_0003);
        cyc(0, 0, 0, 0, 1, 3, 1);
        check("active_rd_pre", s_rd_data, 32'h0);
        check("pe3_pre", s_pe[3*DW +: DW], 32'h0);

        // commit of memory/network words
        cyc(1, 16, 32'h11, 0, 0, 0, 0);
        cyc(1, 17, 32'h22, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        check("commit_busy", s_wr_ready, 1'b0);
        check("mem_before", s_mem, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("mem_after", s_mem, 32'h11);
        check("net_after", s_net, 32'h22);
        check("commit_pulse", s_commit_done, 1'b1);
        check("pe3_after", s_pe[3*DW +: DW], 32'hA5A5_0003);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("commit_pulse_end", s_commit_done, 1'b0);

        // same-cycle write+commit, then control-register commit
        cyc(1, 0, 32'hDEAD, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("pe0_dead", s_pe[DW-1:0], 32'hDEAD);
        cyc(1, 0, 32'hBEEF, 0, 0, 0, 0);
        cyc(1, 18, 32'h1, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 1, 0, 1);
        check("pe0_beef", s_pe[DW-1:0], 32'hBEEF);
        check("active_rd_in_commit", s_rd_data, 32'hDEAD);

        // out of range
        cyc(1, 40, 32'hFFFF_FFFF, 0, 0, 0, 0);
        check("oor_wr_err", s_wr_err, 1'b1);
        cyc(0, 0, 0, 0, 1, 40, 1);
        check("oor_rd_err", s_rd_err, 1'b1);
        check("oor_rd_data", s_rd_data, 32'h0);
        cyc(0, 0, 0, 0, 1, 18, 0);
        check("ctrl_rd_zero", s_rd_data, 32'h0);

        // write-through instance
        cyc(1, 5, 32'h55, 0, 0, 0, 0);
        check("wt_pe5", w_pe[5*DW +: DW], 32'h55);
        check("sh_pe5", s_pe[5*DW +: DW], 32'h0);

        // commit held high re-commits every other cycle
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // reset in the middle of a commit
        cyc(1, 9, 32'h9999, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        do_reset();
        check("rst_mid_commit_pe9", s_pe[9*DW +: DW], 32'h0);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            sel = $urandom_range(0, 9);
            wa  = (sel < 8) ? $urandom_range(0, NW) : $urandom_range(0, 63);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 1), wa, $urandom, ($urandom_range(0, 7) == 0),
                    $urandom_range(0, 1), $urandom_range(0, 21), $urandom_range(0, 1));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/npu_config_regfile.md
# npu_config_regfile

Parametrised configuration register file for the NPU, replacing the fixed PE/memory/network config block. Holds one config word per PE plus a memory and a network config word, behind an address/data write handshake with readback. Writes land in a shadow bank and are copied to the active bank atomically on commit, so the PE array never sees a partially updated configuration. Sits between the host/control interface and the PE array, memory controller and NoC.

## Interface
- DATA_WIDTH, 32, width of every config word
- NUM_PE, 16, number of PE config entries (PE_ROWS*PE_COLS at instantiation)
- ADDR_WIDTH, 6, register address width; 2^ADDR_WIDTH >= NUM_PE+3 required
- SHADOW_EN, 1, 1 = shadow/commit mode, 0 = write-through mode
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- wr_valid  in  1  write request
- wr_ready  out  1  write accept; transfer on wr_valid && wr_ready
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_err  out  1  one-cycle pulse: previous accepted write was out of range
- commit  in  1  commit request, level sampled in IDLE
- commit_done  out  1  one-cycle pulse after the active bank is updated
- rd_req  in  1  read request, always accepted
- rd_addr  in  ADDR_WIDTH  read address
- rd_active  in  1  1 = read active bank, 0 = read shadow bank
- rd_valid  out  1  read data valid
- rd_data  out  DATA_WIDTH  read data
- rd_err  out  1  valid with rd_valid: address out of range
- pe_config  out  NUM_PE*DATA_WIDTH  active PE words; entry i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- memory_config  out  DATA_WIDTH  active memory config
- network_config  out  DATA_WIDTH  active network config

## Operation
- Address map: 0..NUM_PE-1 PE entries; NUM_PE memory; NUM_PE+1 network; NUM_PE+2 control (write with wr_data[0]=1 requests commit, reads return 0); anything above is out of range.
- FSM states IDLE, COMMIT. wr_ready = (state == IDLE).
- IDLE: accepted in-range write updates the shadow word (SHADOW_EN=1) or shadow and active word together (SHADOW_EN=0). If commit=1 or a control-register commit write is accepted, go to COMMIT.
- COMMIT: copy all shadow words to active in one edge, pulse commit_done, return to IDLE. SHADOW_EN=0: no copy, commit_done still pulses.
- Out-of-range write: accepted, data discarded, wr_err pulses.
- Read: shadow or active word per rd_active; out-of-range returns 0 with rd_err=1.
- Outputs are driven directly from active-bank registers; no combinational path from inputs.

## Timing
- Reset: all shadow/active words 0, state IDLE, wr_ready=1, wr_err=0, commit_done=0, rd_valid=0, rd_data=0, rd_err=0. Reset mid-commit aborts; active bank clears to 0.
- Write accepted at edge N: shadow word updated at edge N; wr_err high for cycle N..N+1.
- Commit sampled at edge N: state COMMIT in cycle N..N+1 (wr_ready=0); active updated at edge N+1; commit_done high in cycle N+1..N+2. Back-to-back commit: minimum 2 cycles apart; commit held high re-commits every 2 cycles.
- Write and commit in same cycle: write lands in shadow at edge N and is included in the commit at N+1.
- Read at edge N: rd_valid/rd_data/rd_err registered, valid in cycle N..N+1. Read of a word written at edge N returns the new value when issued at edge N+1 or later. Active read in COMMIT cycle returns pre-commit value.

## Test plan
- Reset: assert rst_n=0 mid-stream -> all outputs 0, wr_ready=1, pe_config all 0.
- Shadow isolation (SHADOW_EN=1): write 0xA5A5_0003 to addr 3 -> rd_active=0 returns 0xA5A5_0003, rd_active=1 and pe_config[3] return 0 until commit.
- Commit: write addr 16=0x11, 17=0x22, pulse commit -> wr_ready low 1 cycle, memory_config=0x11, network_config=0x22 at edge N+1, commit_done one pulse.
- Same-cycle write+commit: write addr 0=0xDEAD with commit=1 -> pe_config[0]=0xDEAD after commit; control-register commit (addr 18, data 1) behaves identically.
- Out-of-range: write addr 40 -> wr_err pulse, no register changes; read addr 40 -> rd_data=0, rd_err=1.
- Write-through (SHADOW_EN=0): write addr 5=0x55 -> pe_config[5]=0x55 next cycle, no commit needed; commit still pulses commit_done.
